counter_down_loadable: RTL

Loadable down-counter/timer with start/abort handshake and terminal-count reporting. It is the complementary block to the team's linear up-counter: it loads a value and counts down to zero on each enable tick instead of counting up and wrapping. It serves as the timeout and delay element for the P3 control FSMs, clocked from the same enable ticks as the up-counters.

---
 rtl/counter_pkg.sv | 26 ++
 rtl/counter_down_loadable.sv | 101 ++++++++++
 2 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the up- and down-counter family: width helper and
// the down-counter state encoding.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } down_state_e;

    // Smallest width able to index 'value' distinct codes; never less than 1.
    function automatic int CeilLog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_down_loadable.sv
// Loadable down-counter/timer: start/abort handshake, saturating load,
// optional auto-reload and a one-cycle done pulse at terminal count.
module counter_down_loadable
    import counter_pkg::*;
#(
    parameter int Maximum_Value   = 9,
    parameter int NBitsForCounter = CeilLog2(Maximum_Value + 1),
    parameter int Auto_Reload     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enb,
    input  logic                       start,
    input  logic [NBitsForCounter-1:0] load_value,
    input  logic                       abort,
    output logic                       busy,
    output logic                       Flag,
    output logic                       done,
    output logic [NBitsForCounter-1:0] Counting
);

    localparam logic [NBitsForCounter-1:0] MAX_C = NBitsForCounter'(Maximum_Value);
    localparam logic [NBitsForCounter-1:0] ONE_C = NBitsForCounter'(1);

    down_state_e                state_q, state_d;
    logic [NBitsForCounter-1:0] count_q, count_d;
    logic [NBitsForCounter-1:0] latch_q, latch_d;
    logic                       done_q, done_d;
    logic [NBitsForCounter-1:0] load_sat;

    assign load_sat = (load_value > MAX_C) ? MAX_C : load_value;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        latch_d = latch_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (start) begin
                    latch_d = load_sat;
                    if (load_sat != '0) begin
                        count_d = load_sat;
                        state_d = RUN;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (enb) begin
                    if (count_q > ONE_C) begin
                        count_d = count_q - ONE_C;
                    end else begin
                        // Terminal tick; a zero count in RUN is treated the same so it cannot underflow.
                        done_d = 1'b1;
                        if (Auto_Reload != 0) begin
                            count_d = latch_q;
                        end else begin
                            count_d = '0;
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                count_d = '0;
                state_d = IDLE;
            end
            default: begin
                count_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            latch_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            latch_q <= latch_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign Flag     = (state_q == RUN) && (count_q == ONE_C);
    assign done     = done_q;
    assign Counting = count_q;

endmodule
